bin2bcd_seq: RTL and testbench
==============================

BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 clk  input  1  single system clock, all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 bin  input  14  unsigned binary value to convert; sampled only on the edge that accepts start.
REQ-005 start  input  1  conversion request; level-sampled, accepted only in IDLE.
REQ-006 busy  output  1  high while a conversion is in progress.
REQ-007 done  output  1  one-cycle pulse; the result outputs are valid from this cycle on.
REQ-008 ovf  output  1  high when the last accepted bin exceeded 9999.
REQ-009 bcd3, bcd2, bcd1, bcd0  output  4 each  thousands, hundreds, tens and units digits; each is a 4-bit BCD digit that drives the 4-bit inputs of the display multiplexer stage directly.

Function
REQ-010 The block SHALL implement a two-state machine: IDLE and CONV.
REQ-011 In IDLE with start=1 at edge N, it SHALL:
- latch bin into a 14-bit shift register;
- clear a 20-bit BCD scratch register and a 4-bit step counter;
- latch ovf_pending = (bin > 9999);
- enter CONV.
REQ-012 In CONV, each edge SHALL perform one shift-add-3 step:
- add 3 to every scratch nibble whose value is >= 5;
- then shift {scratch, shift register} left by one bit;
- increment the step counter.
REQ-013 CONV SHALL last exactly 14 edges (N+1..N+14).
REQ-014 On edge N+14 the block SHALL:
- load bcd3..bcd0 from the final scratch nibbles;
- load ovf from ovf_pending;
- set done=1;
- return to IDLE.
REQ-015 done SHALL be high for exactly the one cycle following edge N+14 and low at all other times.
REQ-016 busy SHALL equal (state==CONV); it is high after edges N..N+13 and low after edge N+14.
REQ-017 When ovf_pending=1, the loaded digits SHALL be 9,9,9,9 (clamped) instead of the converted value.
REQ-018 bcd3..bcd0 and ovf SHALL hold their last loaded values until the next done; intermediate scratch values SHALL never appear on the outputs.
REQ-019 start asserted while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-020 start asserted during the done cycle SHALL be accepted, since the state is IDLE; back-to-back conversions SHALL therefore have a period of 15 cycles.
REQ-021 Changes on bin after the accepting edge SHALL NOT affect the result in progress.
REQ-022 Every output digit SHALL be in the range 0..9 at all times.

Reset
REQ-023 rst=1 at any edge, including mid-conversion, SHALL force:
- state=IDLE, step counter=0, scratch=0;
- busy=0, done=0, ovf=0;
- bcd3..bcd0=0.
REQ-024 rst SHALL take priority over start on the same edge; the conversion in progress is abandoned with no done pulse.
REQ-025 On the first edge with rst=0, the block SHALL accept start normally.

Verification
REQ-026 bin=1234, start for 1 cycle at edge N -> busy high after edges N..N+13; done pulse after edge N+14; bcd3..0=1,2,3,4; ovf=0.
REQ-027 bin=0, then bin=9999 (separate conversions) -> 0,0,0,0 ovf=0, then 9,9,9,9 ovf=0; each done exactly 14 cycles after its start edge.
REQ-028 bin=10000, then bin=16383 -> both give 9,9,9,9 with ovf=1; a following bin=57 gives 0,0,5,7 with ovf=0.
REQ-029 start=1 held continuously with bin changing every cycle -> conversions accepted only every 15 cycles; each result matches the bin present on its accepting edge; exactly one done per conversion.
REQ-030 bin=4321 started, rst=1 pulsed on edge N+7 -> busy=0, digits 0,0,0,0, and no done pulse; a new start of bin=8 then gives 0,0,0,8 after 14 cycles.
REQ-031 Exhaustive sweep of bin=0..9999 -> every result equals the decimal digits of bin; no digit ever exceeds 9.

Source files
------------

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq -- sequential 14-bit binary to 4-digit BCD converter.
//
// Uses the shift-add-3 (double dabble) algorithm, one bit per clock.
// A conversion is accepted in IDLE. It runs for 14 CONV cycles and ends with a
// one-cycle done pulse, which is where the result registers are loaded.
// Inputs above 9999 do not fit in four digits. They are reported on ovf and
// the digits are clamped to 9999.
//
// Ports:
//   clk              system clock, rising edge
//   rst              synchronous active-high reset
//   bin[13:0]        value to convert, sampled on the accepting edge only
//   start            conversion request, honoured only in IDLE
//   busy             high while converting
//   done             one-cycle pulse, results valid from this cycle on
//   ovf              last accepted value exceeded 9999
//   bcd3..bcd0[3:0]  thousands .. units digits, held until the next done
module bin2bcd_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic [13:0] bin,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        ovf,
    output logic [3:0]  bcd3,
    output logic [3:0]  bcd2,
    output logic [3:0]  bcd1,
    output logic [3:0]  bcd0
);

    typedef enum logic {IDLE, CONV} state_t;

    state_t      r_state;
    logic [13:0] r_shift;
    logic [19:0] r_scr;
    logic [3:0]  r_cnt;
    logic        r_ovf_pend;
    logic        r_done;
    logic        r_ovf;
    logic [15:0] r_bcd;

    logic [19:0] w_adj;
    logic [19:0] w_next;
    logic        w_clamp;

    // Add 3 to every nibble that is 5 or more, so the following shift carries
    // into the next decimal digit correctly.
    always_comb begin
        w_adj = r_scr;
        for (int k = 0; k < 5; k++) begin
            if (r_scr[4*k +: 4] >= 4'd5)
                w_adj[4*k +: 4] = r_scr[4*k +: 4] + 4'd3;
        end
    end

    // Scratch after this step: the adjusted value shifted left by one, with
    // the next binary bit shifted in at the bottom.
    assign w_next = {w_adj[18:0], r_shift[13]};

    // With an input of 9999 or less, the fifth nibble stays zero. Any bit set
    // up there can only come from an out-of-range value. Clamping on that
    // condition as well as on ovf_pending means a digit above 9 can never be
    // loaded onto the outputs.
    assign w_clamp = r_ovf_pend | (|w_next[19:16]) | w_adj[19];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_scr      <= '0;
            r_cnt      <= '0;
            r_ovf_pend <= 1'b0;
            r_done     <= 1'b0;
            r_ovf      <= 1'b0;
            r_bcd      <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_shift    <= bin;
                        r_scr      <= '0;
                        r_cnt      <= '0;
                        r_ovf_pend <= (bin > 14'd9999);
                        r_state    <= CONV;
                    end
                end
                CONV: begin
                    r_scr   <= w_next;
                    r_shift <= {r_shift[12:0], 1'b0};
                    r_cnt   <= r_cnt + 4'd1;
                    // The 14th step completes the conversion. The results are
                    // taken from this step's scratch value, not from r_scr.
                    if (r_cnt == 4'd13) begin
                        r_state <= IDLE;
                        r_done  <= 1'b1;
                        r_ovf   <= r_ovf_pend;
                        r_bcd   <= w_clamp ? 16'h9999 : w_next[15:0];
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy = (r_state == CONV);
    assign done = r_done;
    assign ovf  = r_ovf;
    assign bcd3 = r_bcd[15:12];
    assign bcd2 = r_bcd[11:8];
    assign bcd1 = r_bcd[7:4];
    assign bcd0 = r_bcd[3:0];

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed vectors with hand-computed digits.
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic [13:0] bin;
    logic        start;
    logic        busy, done, ovf;
    logic [3:0]  bcd3, bcd2, bcd1, bcd0;

    int errors = 0;
    int checks = 0;

    bin2bcd_seq dut (
        .clk(clk), .rst(rst), .bin(bin), .start(start),
        .busy(busy), .done(done), .ovf(ovf),
        .bcd3(bcd3), .bcd2(bcd2), .bcd1(bcd1), .bcd0(bcd0)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] digits();
        return {bcd3, bcd2, bcd1, bcd0};
    endfunction

    // Decimal digits of v, clamped to 9999 when out of range.
    function automatic logic [15:0] exp_digits(input int v);
        if (v > 9999) return 16'h9999;
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Runs one conversion with a single-cycle start pulse.
    // lat: edges from the accepting edge to done (40 = timeout).
    // bcnt: busy cycles seen before done.
    // held: outputs did not change while converting.
    // bin is scrambled right after acceptance to show it is not re-sampled.
    task automatic do_conv(input logic [13:0] val, output int lat, output int bcnt,
                           output bit held);
        logic [15:0] prev;
        @(negedge clk);
        bin = val; start = 1'b1;
        prev = digits();
        held = 1'b1;
        @(negedge clk);
        start = 1'b0; bin = 14'h2AAA;
        lat = 0; bcnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (done) break;
            if (busy) bcnt++;
            if (digits() !== prev) held = 1'b0;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; bin = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, ovf, digits()} !== 19'd0) begin
            errors++; $display("FAIL reset_state: got %h want 0", {busy, done, ovf, digits()});
        end
        // Reset wins over start on the same edge.
        start = 1'b1; bin = 14'd77;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL reset_over_start: busy got %b want 0", busy);
        end
        rst = 1'b0; start = 1'b0;
    endtask

    task automatic test_basic();
        int lat, bcnt; bit held;
        do_conv(14'd1234, lat, bcnt, held);
        checks++;
        if (lat !== 14) begin errors++; $display("FAIL basic_latency: got %0d want 14", lat); end
        checks++;
        if (bcnt !== 14) begin errors++; $display("FAIL basic_busy_cycles: got %0d want 14", bcnt); end
        checks++;
        if ({busy, ovf, digits()} !== {2'b00, 16'h1234}) begin
            errors++; $display("FAIL basic_result: got busy=%b ovf=%b %h want 0 0 1234", busy, ovf, digits());
        end
        @(negedge clk);
        checks++;
        if ({done, digits()} !== {1'b0, 16'h1234}) begin
            errors++; $display("FAIL basic_done_pulse_hold: got done=%b %h want 0 1234", done, digits());
        end
    endtask

    task automatic test_bounds();
        int lat, bcnt; bit held;
        do_conv(14'd0, lat, bcnt, held);
        checks++;
        if ({lat[4:0], ovf, digits()} !== {5'd14, 1'b0, 16'h0000}) begin
            errors++; $display("FAIL bound_zero: got lat=%0d ovf=%b %h want 14 0 0000", lat, ovf, digits());
        end
        do_conv(14'd9999, lat, bcnt, held);
        checks++;
        if ({lat[4:0], ovf, digits()} !== {5'd14, 1'b0, 16'h9999}) begin
            errors++; $display("FAIL bound_9999: got lat=%0d ovf=%b %h want 14 0 9999", lat, ovf, digits());
        end
        do_conv(14'd10000, lat, bcnt, held);
        checks++;
        if ({ovf, digits()} !== {1'b1, 16'h9999}) begin
            errors++; $display("FAIL ovf_10000: got ovf=%b %h want 1 9999", ovf, digits());
        end
        do_conv(14'd16383, lat, bcnt, held);
        checks++;
        if ({ovf, digits()} !== {1'b1, 16'h9999}) begin
            errors++; $display("FAIL ovf_16383: got ovf=%b %h want 1 9999", ovf, digits());
        end
        do_conv(14'd57, lat, bcnt, held);
        checks++;
        if ({ovf, digits()} !== {1'b0, 16'h0057}) begin
            errors++; $display("FAIL after_ovf_57: got ovf=%b %h want 0 0057", ovf, digits());
        end
        checks++;
        if (held !== 1'b1) begin
            errors++; $display("FAIL outputs_held_during_conv: got held=%b want 1", held);
        end
    endtask

    task automatic test_ignore_start();
        int ndone = 0;
        @(negedge clk);
        bin = 14'd2468; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        bin = 14'd1111; start = 1'b1;   // pulse while busy: must be dropped
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        checks++;
        if (ndone !== 1) begin errors++; $display("FAIL ignore_start_done_count: got %0d want 1", ndone); end
        checks++;
        if (digits() !== 16'h2468) begin
            errors++; $display("FAIL ignore_start_result: got %h want 2468", digits());
        end
    endtask

    task automatic test_back_to_back();
        int v[60];
        int ndone = 0, bad_timing = 0;
        for (int i = 0; i < 60; i++) v[i] = (i * 613 + 29) % 10000;
        @(negedge clk);
        for (int i = 0; i < 60; i++) begin
            bin = 14'(v[i]); start = 1'b1;
            @(negedge clk);
            if ((i % 15) == 14) begin
                if (done !== 1'b1) bad_timing++;
                else begin
                    ndone++;
                    checks++;
                    if (digits() !== exp_digits(v[i-14])) begin
                        errors++;
                        $display("FAIL b2b_result_%0d: got %h want %h", i, digits(), exp_digits(v[i-14]));
                    end
                end
            end else if (done !== 1'b0) bad_timing++;
        end
        start = 1'b0;
        checks++;
        if (bad_timing !== 0) begin errors++; $display("FAIL b2b_done_timing: got %0d bad cycles want 0", bad_timing); end
        checks++;
        if (ndone !== 4) begin errors++; $display("FAIL b2b_done_count: got %0d want 4", ndone); end
    endtask

    task automatic test_reset_mid();
        int lat, bcnt, ndone; bit held;
        @(negedge clk);
        bin = 14'd4321; start = 1'b1;
        @(negedge clk);                 // after accepting edge N
        start = 1'b0;
        repeat (6) @(negedge clk);      // after N+6
        rst = 1'b1;
        @(negedge clk);                 // after N+7
        checks++;
        if ({busy, done, ovf, digits()} !== 19'd0) begin
            errors++; $display("FAIL reset_mid_conv: got %h want 0", {busy, done, ovf, digits()});
        end
        rst = 1'b0;
        ndone = 0;
        for (int k = 0; k < 20; k++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        checks++;
        if (ndone !== 0) begin errors++; $display("FAIL reset_mid_no_done: got %0d want 0", ndone); end
        do_conv(14'd8, lat, bcnt, held);
        checks++;
        if ({lat[4:0], digits()} !== {5'd14, 16'h0008}) begin
            errors++; $display("FAIL reset_then_8: got lat=%0d %h want 14 0008", lat, digits());
        end
    endtask

    task automatic test_sweep();
        int lat, bcnt, nrange = 0; bit held;
        for (int v = 0; v <= 9999; v += 37) begin
            do_conv(14'(v), lat, bcnt, held);
            checks++;
            if ({lat[5:0], ovf, digits()} !== {6'd14, 1'b0, exp_digits(v)}) begin
                errors++;
                $display("FAIL sweep_%0d: got lat=%0d ovf=%b %h want 14 0 %h", v, lat, ovf, digits(), exp_digits(v));
            end
            if (bcd3 > 9 || bcd2 > 9 || bcd1 > 9 || bcd0 > 9) nrange++;
        end
        checks++;
        if (nrange !== 0) begin errors++; $display("FAIL sweep_digit_range: got %0d bad want 0", nrange); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bounds();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
